// File: rtl/common_apb3_regbank_if.sv
// APB3 bus bundle between the SoC bridge and the vision register bank.
// Master drives address/control/write data; slave returns data and status.
interface common_apb3_regbank_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERROR;

    modport master (
        output PADDR,
        output PSEL,
        output PENABLE,
        output PWRITE,
        output PWDATA,
        input  PRDATA,
        input  PREADY,
        input  PSLVERROR
    );

    modport slave (
        input  PADDR,
        input  PSEL,
        input  PENABLE,
        input  PWRITE,
        input  PWDATA,
        output PRDATA,
        output PREADY,
        output PSLVERROR
    );
endinterface

// File: rtl/common_apb3_regbank.sv
// APB3 register bank: RW control regs with write strobes, live status regs,
// W1C interrupt status with enable mask, ID register and wait states.
module common_apb3_regbank #(
    parameter int ADDR_WIDTH                = 12,
    parameter int DATA_WIDTH                = 32,
    parameter int NUM_CTRL                  = 8,
    parameter int NUM_STAT                  = 10,
    parameter int NUM_IRQ                   = 8,
    parameter int WAIT_STATES               = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hABCD_5678
) (
    input  logic                           clk,
    input  logic                           reset,
    common_apb3_regbank_if.slave           bus,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out,
    output logic [NUM_CTRL-1:0]            ctrl_wr_pulse,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_in,
    input  logic [NUM_IRQ-1:0]             irq_src,
    output logic                           irq
);
    localparam int IW    = ADDR_WIDTH - 2;
    localparam int S_IDX = NUM_CTRL + NUM_STAT;

    localparam logic [IW-1:0] STAT_LO = IW'(NUM_CTRL);
    localparam logic [IW-1:0] IRQ_ST  = IW'(S_IDX);
    localparam logic [IW-1:0] IRQ_EN  = IW'(S_IDX + 1);
    localparam logic [IW-1:0] ID_IDX  = IW'(S_IDX + 2);
    localparam logic [3:0]    WS      = 4'(WAIT_STATES);

    logic [IW-1:0] idx;
    logic          unused_addr_lsb;

    logic access;
    logic ready;
    logic wr_done;

    logic hit_ctrl;
    logic hit_stat;
    logic hit_st;
    logic hit_en;
    logic hit_id;
    logic mapped;

    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;

    logic [DATA_WIDTH-1:0] ctrl_q [NUM_CTRL];
    logic [DATA_WIDTH-1:0] ctrl_d [NUM_CTRL];
    logic [NUM_CTRL-1:0]   ctrl_we;
    logic [NUM_CTRL-1:0]   pulse_q;

    logic [NUM_IRQ-1:0] irq_st_q;
    logic [NUM_IRQ-1:0] irq_st_d;
    logic [NUM_IRQ-1:0] irq_en_q;
    logic [NUM_IRQ-1:0] irq_en_d;
    logic [NUM_IRQ-1:0] irq_clr;
    logic               irq_q;
    logic               irq_d;

    logic [DATA_WIDTH-1:0] rdata;

    assign idx             = bus.PADDR[ADDR_WIDTH-1:2];
    assign unused_addr_lsb = ^bus.PADDR[1:0];

    // Address decode; anything above the ID word is unmapped.
    assign hit_ctrl = idx < STAT_LO;
    assign hit_stat = (idx >= STAT_LO) && (idx < IRQ_ST);
    assign hit_st   = idx == IRQ_ST;
    assign hit_en   = idx == IRQ_EN;
    assign hit_id   = idx == ID_IDX;
    assign mapped   = hit_ctrl | hit_stat | hit_st | hit_en | hit_id;

    assign access  = bus.PSEL & bus.PENABLE;
    assign ready   = access & (wait_cnt_q == WS) & ~reset;
    assign wr_done = ready & bus.PWRITE;

    always_comb begin
        wait_cnt_d = '0;
        if (access && !ready) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_comb begin
        ctrl_we = '0;
        for (int k = 0; k < NUM_CTRL; k++) begin
            ctrl_we[k] = wr_done && hit_ctrl && (idx == IW'(k));
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CTRL; k++) begin
            ctrl_d[k] = ctrl_we[k] ? bus.PWDATA : ctrl_q[k];
        end
    end

    // A source pulse in the same cycle as a W1C keeps the bit set.
    always_comb begin
        irq_clr = '0;
        if (wr_done && hit_st) begin
            irq_clr = bus.PWDATA[NUM_IRQ-1:0];
        end
        irq_st_d = (irq_st_q & ~irq_clr) | irq_src;
        irq_en_d = irq_en_q;
        if (wr_done && hit_en) begin
            irq_en_d = bus.PWDATA[NUM_IRQ-1:0];
        end
        irq_d = |(irq_st_q & irq_en_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            pulse_q    <= '0;
            irq_st_q   <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
            for (int k = 0; k < NUM_CTRL; k++) begin
                ctrl_q[k] <= '0;
            end
        end else begin
            wait_cnt_q <= wait_cnt_d;
            pulse_q    <= ctrl_we;
            irq_st_q   <= irq_st_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            for (int k = 0; k < NUM_CTRL; k++) begin
                ctrl_q[k] <= ctrl_d[k];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (access && !reset) begin
            unique case (1'b1)
                hit_ctrl: begin
                    for (int k = 0; k < NUM_CTRL; k++) begin
                        if (idx == IW'(k)) begin
                            rdata = ctrl_q[k];
                        end
                    end
                end
                hit_stat: begin
                    for (int k = 0; k < NUM_STAT; k++) begin
                        if (idx == IW'(NUM_CTRL + k)) begin
                            rdata = stat_in[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                hit_st: rdata[NUM_IRQ-1:0] = irq_st_q;
                hit_en: rdata[NUM_IRQ-1:0] = irq_en_q;
                hit_id: rdata = ID_VALUE;
                default: rdata = '0;
            endcase
        end
    end

    assign bus.PRDATA    = rdata;
    assign bus.PREADY    = ready;
    assign bus.PSLVERROR = ready & ~mapped;

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
        assign ctrl_out[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
    end

    assign ctrl_wr_pulse = pulse_q;
    assign irq           = irq_q;
endmodule

// File: tb/tb_common_apb3_regbank.sv
// Scoreboard bench for the APB3 register bank with a word-level reference
// model; the driver queues expectations and a negedge monitor checks them.
module tb_common_apb3_regbank;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NC = 8;
    localparam int NS = 10;
    localparam int NI = 8;
    localparam int WS = 2;
    localparam int S  = NC + NS;
    localparam logic [31:0] ID = 32'hABCD_5678;

    logic clk = 1'b0;
    logic reset = 1'b1;

    common_apb3_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    logic [NC*DW-1:0] ctrl_out;
    logic [NC-1:0]    ctrl_wr_pulse;
    logic [NS*DW-1:0] stat_in;
    logic [NI-1:0]    irq_src;
    logic             irq;

    common_apb3_regbank #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_CTRL   (NC),
        .NUM_STAT   (NS),
        .NUM_IRQ    (NI),
        .WAIT_STATES(WS),
        .ID_VALUE   (ID)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .ctrl_out     (ctrl_out),
        .ctrl_wr_pulse(ctrl_wr_pulse),
        .stat_in      (stat_in),
        .irq_src      (irq_src),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            wr;
        logic [31:0]   rdata;
        bit            err;
        logic [NC-1:0] pulse;
    } exp_t;

    exp_t q[$];

    logic [31:0] m_ctrl [NC];
    logic [31:0] m_stat [NS];
    logic [NI-1:0] m_st;
    logic [NI-1:0] m_en;

    int n_cmp = 0;
    int n_fail = 0;
    int acc = 0;
    logic [NC-1:0] exp_pulse = '0;

    for (genvar g = 0; g < NS; g++) begin : g_stat
        assign stat_in[g*DW +: DW] = m_stat[g];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: strobe check every cycle, scoreboard pop on each PREADY.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            acc = 0;
            exp_pulse = '0;
        end else begin
            check("wr_pulse", 32'(ctrl_wr_pulse), 32'(exp_pulse));
            exp_pulse = '0;
            if (bus.PSEL && bus.PENABLE) begin
                acc++;
                if (bus.PREADY) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_ready: got PREADY=1 with empty queue");
                    end else begin
                        e = q.pop_front();
                        check("wait_cycles", 32'(acc), 32'(WS + 1));
                        check("pslverr", 32'(bus.PSLVERROR), 32'(e.err));
                        if (!e.wr) check("prdata", bus.PRDATA, e.rdata);
                        else exp_pulse = e.pulse;
                    end
                    acc = 0;
                end
            end else begin
                acc = 0;
                check("idle_ready", 32'(bus.PREADY), 32'd0);
            end
        end
    end

    task automatic xfer(input bit wr, input int idx, input logic [31:0] wd,
                        input logic [NI-1:0] src);
        exp_t e;
        bit done;
        e.wr = wr;
        e.rdata = '0;
        e.err = 1'b0;
        e.pulse = '0;
        if (idx < NC) begin
            if (wr) begin
                m_ctrl[idx] = wd;
                e.pulse = NC'(1) << idx;
            end else e.rdata = m_ctrl[idx];
        end else if (idx < S) begin
            if (!wr) e.rdata = m_stat[idx-NC];
        end else if (idx == S) begin
            if (wr) m_st = m_st & ~wd[NI-1:0];
            else e.rdata = 32'(m_st);
        end else if (idx == S + 1) begin
            if (wr) m_en = wd[NI-1:0];
            else e.rdata = 32'(m_en);
        end else if (idx == S + 2) begin
            if (!wr) e.rdata = ID;
        end else begin
            e.err = 1'b1;
        end
        m_st = m_st | src;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.PSEL = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE = wr;
        bus.PADDR = AW'(idx * 4 + int'($urandom_range(0, 3)));
        bus.PWDATA = wr ? wd : $urandom;
        @(posedge clk);
        #1;
        bus.PENABLE = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.PREADY) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: idx %0d got no PREADY within 20 cycles", idx);
        end
        irq_src = src;
        @(posedge clk);
        #1;
        bus.PSEL = 1'b0;
        bus.PENABLE = 1'b0;
        irq_src = '0;
    endtask

    task automatic pulse(input logic [NI-1:0] v);
        @(posedge clk);
        #1;
        irq_src = v;
        @(posedge clk);
        #1;
        irq_src = '0;
        m_st = m_st | v;
    endtask

    task automatic settle_irq(input string name);
        repeat (2) @(posedge clk);
        #1;
        check(name, 32'(irq), 32'(|(m_st & m_en)));
    endtask

    task automatic check_ctrl();
        for (int k = 0; k < NC; k++) begin
            check("ctrl_out", ctrl_out[k*DW +: DW], m_ctrl[k]);
        end
    endtask

    initial begin
        int idx;
        bus.PSEL = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE = 1'b0;
        bus.PADDR = '0;
        bus.PWDATA = '0;
        irq_src = '0;
        m_st = '0;
        m_en = '0;
        for (int k = 0; k < NC; k++) m_ctrl[k] = '0;
        for (int k = 0; k < NS; k++) m_stat[k] = $urandom;
        m_stat[0] = 32'h55;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_prdata", bus.PRDATA, 32'd0);
        check("rst_pready", 32'(bus.PREADY), 32'd0);
        check("rst_pslverr", 32'(bus.PSLVERROR), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_pulse", 32'(ctrl_wr_pulse), 32'd0);

        xfer(0, 0, 0, '0);
        xfer(0, S + 2, 0, '0);
        xfer(1, 1, 32'h0000_0003, '0);
        check("ctrl1", ctrl_out[63:32], 32'd3);
        xfer(0, 1, 0, '0);
        xfer(0, 8, 0, '0);
        xfer(0, 255, 0, '0);
        xfer(1, 255, 32'hFFFF_FFFF, '0);
        check_ctrl();

        xfer(1, S + 1, 32'h08, '0);
        pulse(8'h08);
        settle_irq("irq_set");
        xfer(1, S, 32'h08, '0);
        settle_irq("irq_clr");
        xfer(1, S, 32'h08, 8'h08);
        xfer(0, S, 0, '0);
        settle_irq("irq_race");
        xfer(1, S, 32'h0, '0);
        xfer(0, S, 0, '0);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) idx = int'($urandom_range(S + 3, 1023));
            else idx = int'($urandom_range(0, S + 2));
            xfer(bit'($urandom_range(0, 1)), idx, $urandom, '0);
            if ($urandom_range(0, 4) == 0) pulse(NI'($urandom));
            if (i == 40) m_stat[$urandom_range(0, NS - 1)] = $urandom;
        end
        settle_irq("irq_rand");
        check_ctrl();
        xfer(0, S, 0, '0);
        xfer(0, S + 1, 0, '0);

        @(posedge clk);
        #1;
        bus.PSEL = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE = 1'b1;
        bus.PADDR = '0;
        bus.PWDATA = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.PENABLE = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_pready", 32'(bus.PREADY), 32'd0);
        @(posedge clk);
        #1;
        bus.PSEL = 1'b0;
        bus.PENABLE = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < NC; k++) m_ctrl[k] = '0;
        m_st = '0;
        m_en = '0;
        check("rst_mid_ctrl0", ctrl_out[31:0], 32'd0);
        check_ctrl();
        xfer(0, 0, 0, '0);
        settle_irq("irq_after_rst");

        for (int c = 0; c < 50 && q.size() != 0; c++) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end
endmodule
